// File: rtl/debug_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_tx_arbiter_if
// Brief    : Requester and UART-TX byte-stream signals of debug_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface debug_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [8*N_REQ-1:0] i_req_data;
    logic [N_REQ-1:0]   i_req_valid;
    logic [N_REQ-1:0]   o_req_ready;
    logic               i_wready;
    logic [7:0]         o_wdata;
    logic               o_wvalid;
    logic               o_busy;

    // The arbiter drives the framed byte stream, so it is the master side.
    modport master (
        input  i_req_data,
        input  i_req_valid,
        input  i_wready,
        output o_req_ready,
        output o_wdata,
        output o_wvalid,
        output o_busy
    );

    modport slave (
        output i_req_data,
        output i_req_valid,
        output i_wready,
        input  o_req_ready,
        input  o_wdata,
        input  o_wvalid,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/debug_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : debug_tx_arbiter
// Brief    : Round-robin framing arbiter sharing one UART TX stream, with an
//            idle-link heartbeat frame.
// Revision : 1.0 - initial release
// ============================================================================
module debug_tx_arbiter #(
    parameter int          N_REQ        = 4,
    parameter logic [31:0] IDLE_TIMEOUT = 32'h59682eff,
    parameter logic [7:0]  START_BYTE   = 8'h68,
    parameter logic [7:0]  BEAT_BYTE    = 8'h65
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    debug_tx_arbiter_if.master bus
);
    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ID   = 3'd2,
        ST_DATA = 3'd3,
        ST_BEAT = 3'd4
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [7:0]         r_wdata,  w_wdata_nxt;
    logic               r_wvalid, w_wvalid_nxt;
    logic               r_busy;
    logic [c_ptr_w-1:0] r_rr_ptr, w_rr_ptr_nxt, w_rr_inc;
    logic [31:0]        r_wdog,   w_wdog_nxt;
    logic               r_beat,   w_beat_nxt;
    logic [7:0]         r_data,   w_data_nxt;
    logic [2:0]         r_chan,   w_chan_nxt;

    logic [7:0]         w_valid8;
    logic [63:0]        w_data64;
    logic [3:0]         w_cand;
    logic               w_found;
    logic [2:0]         w_win;
    logic [N_REQ-1:0]   w_ready;
    logic               w_accept;

    // Zero-pad the requester buses so a 3-bit channel index fits them exactly.
    assign w_valid8 = 8'(bus.i_req_valid);
    assign w_data64 = 64'(bus.i_req_data);
    assign w_accept = r_wvalid & bus.i_wready;

    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand  = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = 4'(r_rr_ptr) + 4'(i);
            if (w_cand >= 4'(N_REQ)) begin
                w_cand = w_cand - 4'(N_REQ);
            end
            if (!w_found && w_valid8[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[2:0];
            end
        end
    end

    assign w_rr_inc = (({1'b0, w_win} + 4'd1) >= 4'(N_REQ)) ? '0
                    : c_ptr_w'(w_win + 3'd1);

    always_comb begin
        w_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_ready[k] = (r_state == ST_IDLE) && w_found && (w_win == 3'(k));
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wdata_nxt  = r_wdata;
        w_wvalid_nxt = r_wvalid;
        w_rr_ptr_nxt = r_rr_ptr;
        w_beat_nxt   = r_beat;
        w_data_nxt   = r_data;
        w_chan_nxt   = r_chan;

        if (r_state != ST_IDLE) begin
            w_wdog_nxt = IDLE_TIMEOUT;
        end else if (r_wdog != 32'd0) begin
            w_wdog_nxt = r_wdog - 32'd1;
        end else begin
            w_wdog_nxt = r_wdog;
        end

        case (r_state)
            ST_IDLE: begin
                // A pending request always wins over an expired watchdog.
                if (w_found) begin
                    w_state_nxt  = ST_HDR;
                    w_beat_nxt   = 1'b0;
                    w_chan_nxt   = w_win;
                    w_data_nxt   = w_data64[{w_win, 3'b000} +: 8];
                    w_rr_ptr_nxt = w_rr_inc;
                    w_wvalid_nxt = 1'b1;
                    w_wdata_nxt  = START_BYTE;
                end else if (r_wdog == 32'd0) begin
                    w_state_nxt  = ST_HDR;
                    w_beat_nxt   = 1'b1;
                    w_wvalid_nxt = 1'b1;
                    w_wdata_nxt  = START_BYTE;
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    w_state_nxt = r_beat ? ST_BEAT : ST_ID;
                    w_wdata_nxt = r_beat ? BEAT_BYTE : {5'b0, r_chan};
                end
            end
            ST_ID: begin
                if (w_accept) begin
                    w_state_nxt = ST_DATA;
                    w_wdata_nxt = r_data;
                end
            end
            ST_DATA, ST_BEAT: begin
                if (w_accept) begin
                    w_state_nxt  = ST_IDLE;
                    w_wvalid_nxt = 1'b0;
                    w_wdata_nxt  = 8'h00;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_wvalid_nxt = 1'b0;
                w_wdata_nxt  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_wdata  <= 8'h00;
            r_wvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_rr_ptr <= '0;
            r_wdog   <= IDLE_TIMEOUT;
            r_beat   <= 1'b0;
            r_data   <= 8'h00;
            r_chan   <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wvalid <= w_wvalid_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_rr_ptr <= w_rr_ptr_nxt;
            r_wdog   <= w_wdog_nxt;
            r_beat   <= w_beat_nxt;
            r_data   <= w_data_nxt;
            r_chan   <= w_chan_nxt;
        end
    end

    assign bus.o_req_ready = w_ready;
    assign bus.o_wdata     = r_wdata;
    assign bus.o_wvalid    = r_wvalid;
    assign bus.o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_tx_arbiter
// Brief    : Scoreboard bench for debug_tx_arbiter against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_tx_arbiter_if #(.N_REQ(N)) bus ();

    debug_tx_arbiter #(
        .N_REQ       (N),
        .IDLE_TIMEOUT(32'(TMO)),
        .START_BYTE  (8'h68),
        .BEAT_BYTE   (8'h65)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // Model: bytes left in the current frame, idle cycles seen, next priority.
    int m_left = 0;
    int m_idle = 0;
    int m_rr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.o_wvalid && bus.i_wready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL byte_unexpected: got 0x%0h, want no byte (t=%0t)", bus.o_wdata, $time);
            end else begin
                check("byte", 32'(bus.o_wdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycle(input logic [N-1:0] v, input logic [8*N-1:0] d,
                         input logic wr, input logic r);
        logic [N-1:0] exp_rdy;
        int win;
        rst             = r;
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        bus.i_wready    = wr;
        #1;
        if (r) begin
            exp_q.delete();
            m_left = 0;
            m_idle = 0;
            m_rr   = 0;
        end else begin
            win = -1;
            if (m_left == 0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_rr + i) % N;
                    if (win < 0 && v[k]) win = k;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("ready",  32'(bus.o_req_ready), 32'(exp_rdy));
            check("wvalid", 32'(bus.o_wvalid), (m_left > 0) ? 32'd1 : 32'd0);
            check("busy",   32'(bus.o_busy),   (m_left > 0) ? 32'd1 : 32'd0);
            if (m_left == 0) check("wdata_idle", 32'(bus.o_wdata), 32'd0);

            if (m_left > 0) begin
                if (wr) m_left--;
            end else if (win >= 0) begin
                exp_q.push_back(8'h68);
                exp_q.push_back(8'(win));
                exp_q.push_back(d[8*win +: 8]);
                m_left = 3;
                m_rr   = (win + 1) % N;
                m_idle = 0;
            end else if (m_idle >= TMO) begin
                exp_q.push_back(8'h68);
                exp_q.push_back(8'h65);
                m_left = 2;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cycle('0, '0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [8*N-1:0] d;
        logic [N-1:0]   v;
        int             dens;
        logic [2:0]     bp [6];

        rst             = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_wready    = 1'b0;
        @(posedge clk);
        #2;
        do_reset();

        // single request on channel 2
        cycle(4'b0100, 32'h00A5_0000, 1'b1, 1'b0);
        idle(5);

        // all four requesters continuously, frames ch0..ch3, ch0
        do_reset();
        d = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 20; i++) cycle(4'hF, d, 1'b1, 1'b0);
        idle(5);

        // backpressure on a ch1 frame
        bp = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
        cycle(4'b0010, 32'h0000_3C00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle('0, '0, bp[i][0], 1'b0);
        idle(4);

        // heartbeat-only link
        do_reset();
        idle(45);

        // request collides with watchdog expiry
        do_reset();
        for (int i = 0; i < TMO; i++) cycle('0, '0, 1'b1, 1'b0);
        cycle(4'b0001, 32'h0000_00C3, 1'b1, 1'b0);
        idle(25);

        // reset during a stalled ID byte
        cycle(4'b0010, 32'h0000_5A00, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b0);
        cycle(4'hF, 32'h4433_2211, 1'b1, 1'b0);
        idle(5);

        // randomized traffic
        dens = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       dens = 0;
                    1:       dens = 5;
                    2:       dens = 50;
                    default: dens = 100;
                endcase
            end
            v = ($urandom_range(0, 99) < dens) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 499) == 0) begin
                cycle(v, 32'($urandom), 1'($urandom), 1'b1);
            end else begin
                cycle(v, 32'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
            end
        end

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() != 0 || m_left != 0) cycle('0, '0, 1'b1, 1'b0);
        end
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/debug_tx_arbiter.md
# debug_tx_arbiter

Shares the single UART transmit byte stream between up to N_REQ debug sources, wrapping each byte in a framed packet so the PC side can demultiplex channels. Arbitration is round-robin. When the link has been idle for IDLE_TIMEOUT cycles, the block emits a heartbeat frame. It sits between the debug producers (CPU trace, LCD-bus snooper, etc.) and the UART TX core.

## Interface
- N_REQ, 4, number of requesters (1..8)
- IDLE_TIMEOUT, 32'h59682eff, idle cycles before a heartbeat frame (≈30 s)
- START_BYTE, 8'h68, first byte of every frame
- BEAT_BYTE, 8'h65, heartbeat marker byte
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_req_data  in  8*N_REQ  byte from requester k on bits [8k+7:8k]
- i_req_valid  in  N_REQ  requester k has a byte
- o_req_ready  out  N_REQ  one-hot grant; byte k is consumed when valid[k] & ready[k]
- i_wready  in  1  UART TX accepts o_wdata this cycle
- o_wdata  out  8  byte to UART TX
- o_wvalid  out  1  o_wdata valid; held until accepted
- o_busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, HDR, ID, DATA, BEAT.
- Data frame = START_BYTE, channel id {5'b0,k[2:0]}, data byte (3 bytes).
- Heartbeat frame = START_BYTE, BEAT_BYTE (2 bytes). 0x65 is never a valid channel id.
- IDLE arbitration: the winner is the first k with i_req_valid[k] set, scanning from rr_ptr upward modulo N_REQ.
- o_req_ready is combinational and nonzero only in IDLE. It is one-hot for the winner and zero when no valid is set.
- On grant: latch data and k, set rr_ptr <= (k+1) mod N_REQ, and go to HDR.
- HDR: wait for acceptance, then go to ID if the frame is data, or to BEAT if it is a heartbeat.
- ID: wait for acceptance, then go to DATA.
- DATA: wait for acceptance, then go to IDLE.
- BEAT: wait for acceptance, then go to IDLE.
- Acceptance = o_wvalid & i_wready. In each byte state, o_wvalid stays 1 and o_wdata stays stable until acceptance.
- On the accepting edge, the next byte is loaded into o_wdata. If the accepting state is the last of the frame, o_wvalid <= 0 and o_wdata <= 0 instead.
- Watchdog counter (32-bit):
  - Reloads to IDLE_TIMEOUT when state != IDLE.
  - Decrements by 1 in IDLE while nonzero.
  - Saturates at 0.
- Heartbeat start: in IDLE with watchdog == 0 and no i_req_valid bits set, go to HDR with the heartbeat flag set. No o_req_ready is raised.
- A pending request beats a heartbeat in the same cycle. The watchdog is then reloaded by the data frame.
- Requesters may drop valid before being granted. Only bits valid in the arbitration cycle count.
- rr_ptr is unchanged by heartbeat frames.

## Timing
- Reset values: state IDLE, o_wvalid 0, o_wdata 8'h00, o_req_ready 0 (once out of IDLE/grant), o_busy 0, rr_ptr 0, watchdog IDLE_TIMEOUT, heartbeat flag 0.
- o_wdata, o_wvalid and o_busy are registered. o_req_ready is combinational from state, i_req_valid and rr_ptr.
- Latency: grant in cycle t, then o_wvalid=1 with o_wdata=0x68 in cycle t+1.
- With i_wready held 1:
  - Data frame occupies cycles t+1..t+3, returns to IDLE at t+4, and the next grant can happen at t+4 (4-cycle period).
  - Heartbeat occupies 2 valid cycles.
- i_wready low stalls the current byte indefinitely. No timeout applies outside IDLE.
- Reset mid-frame aborts immediately. o_wvalid is 0 on the cycle after the reset edge, and the partial frame is not resumed.
- N_REQ=1: arbitration degenerates to channel 0 and rr_ptr stays 0.

## Test plan
- Reset, then single request: valid[2]=1 with data 0xA5, i_wready=1. Required: ready[2] for one cycle, then bytes 0x68, 0x02, 0xA5 on consecutive cycles, o_wvalid low afterwards.
- All four valid continuously with data 0x10..0x13 (channel k carries 0x10+k). Required: frames in order ch0, ch1, ch2, ch3, ch0, with a 4-cycle frame period.
- Backpressure: i_wready pattern 0,0,1,0,1,1 during a ch1/0x3C frame. Required: each byte held stable until accepted, correct 0x68, 0x01, 0x3C sequence, no duplicates.
- Heartbeat with IDLE_TIMEOUT=16 and no requests. Required: frame 0x68, 0x65 after 16+1 idle cycles, repeating every 16+3 cycles with i_wready=1.
- Collision with IDLE_TIMEOUT=16: valid[0] asserted in the cycle watchdog reaches 0. Required: data frame sent instead of heartbeat, watchdog reloaded, no 0x65 byte.
- Reset asserted during the ID byte of a frame with i_wready=0. Required: o_wvalid=0 next cycle, rr_ptr=0, next grant starts with channel 0 priority.
